data_mem_arbiter: RTL

Arbiter sharing the single DataMem port between the pipeline's MEM stage and an external loader/debug requester (UART boot loader). The CPU has priority; the loader is served in idle MEM cycles or, when starved, by freezing the pipeline for one cycle. The block sits between EX_MEM pipeline outputs and DataMem. Its `cpu_stall` joins the existing LW_Stall/flush logic as a full-pipeline freeze.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/data_mem_arbiter_if.sv | 38 +++
 rtl/arb_starve_cnt.sv | 22 ++
 rtl/data_mem_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the DataMem port arbiter
package mem_arb_pkg;

    typedef enum logic {
        S_CPU,
        S_FORCE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_LD
    } owner_t;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU, loader and DataMem signal bundle for the arbiter
interface data_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cpu_MemRead;
    logic              cpu_MemWrite;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_MemRead, cpu_MemWrite, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, ld_gnt, ld_rvalid, ld_rdata,
        output mem_addr, mem_wdata, mem_MemRead, mem_MemWrite
    );

    modport master (
        output cpu_MemRead, cpu_MemWrite, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, ld_gnt, ld_rvalid, ld_rdata,
        input  mem_addr, mem_wdata, mem_MemRead, mem_MemWrite
    );
endinterface

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating loader-wait counter flagging the last wait before a forced grant
module arb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= 8'd0;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign hit = (cnt == 8'(STARVE_LIMIT - 1));
endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - DataMem port arbiter, CPU first; ARB_STARVE_GUARD_EN adds the forced loader slot
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int unsigned       STARVE_LIMIT = 8,
    parameter logic [ADDR_W-1:0] MMIO_BASE    = ADDR_W'(MMIO_BASE_DEFAULT)
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    logic              cpu_act;
    logic              ld_mmio;
    logic              ld_gnt_c;
    logic              cpu_stall_c;
    owner_t            owner;
    logic              ld_rvalid_q;
    logic [DATA_W-1:0] ld_rdata_q;

    assign cpu_act = bus.cpu_MemRead | bus.cpu_MemWrite;
    assign ld_mmio = (bus.ld_addr >= MMIO_BASE);

`ifdef ARB_STARVE_GUARD_EN
    arb_state_t state;
    arb_state_t state_nxt;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner       = OWN_NONE;
        ld_gnt_c    = 1'b0;
        cpu_stall_c = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            S_FORCE: begin
                // Pipeline is frozen; the held CPU access replays next cycle.
                cpu_stall_c = 1'b1;
                owner       = bus.ld_req ? OWN_LD : OWN_NONE;
                ld_gnt_c    = bus.ld_req;
                cnt_clr     = 1'b1;
                state_nxt   = S_CPU;
            end
            default: begin
                if (cpu_act) begin
                    owner   = OWN_CPU;
                    cnt_inc = bus.ld_req;
                    cnt_clr = ~bus.ld_req;
                    if (bus.ld_req && cnt_hit) begin
                        state_nxt = S_FORCE;
                    end
                end else begin
                    owner    = bus.ld_req ? OWN_LD : OWN_NONE;
                    ld_gnt_c = bus.ld_req;
                    cnt_clr  = 1'b1;
                end
            end
        endcase
    end

    arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .hit  (cnt_hit)
    );
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = STARVE_LIMIT;

    always_comb begin
        owner       = OWN_NONE;
        ld_gnt_c    = 1'b0;
        cpu_stall_c = 1'b0;
        if (cpu_act) begin
            owner = OWN_CPU;
        end else if (bus.ld_req) begin
            owner    = OWN_LD;
            ld_gnt_c = 1'b1;
        end
    end
`endif

    always_comb begin
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_MemRead  = 1'b0;
        bus.mem_MemWrite = 1'b0;
        bus.cpu_rdata    = '0;
        case (owner)
            OWN_CPU: begin
                bus.mem_addr     = bus.cpu_addr;
                bus.mem_wdata    = bus.cpu_wdata;
                bus.mem_MemRead  = bus.cpu_MemRead;
                bus.mem_MemWrite = bus.cpu_MemWrite;
                bus.cpu_rdata    = bus.mem_rdata;
            end
            OWN_LD: begin
                // MMIO beats are acknowledged but never reach DataMem.
                bus.mem_addr     = bus.ld_addr;
                bus.mem_wdata    = bus.ld_wdata;
                bus.mem_MemRead  = ~bus.ld_we & ~ld_mmio;
                bus.mem_MemWrite = bus.ld_we & ~ld_mmio;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            ld_rvalid_q <= ld_gnt_c & ~bus.ld_we;
            if (ld_gnt_c && !bus.ld_we) begin
                ld_rdata_q <= ld_mmio ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.ld_gnt    = ld_gnt_c;
    assign bus.cpu_stall = cpu_stall_c;
    assign bus.ld_rvalid = ld_rvalid_q;
    assign bus.ld_rdata  = ld_rdata_q;
endmodule
